// File: rtl/rv64_pkg.sv
//------------------------------------------------------------------------------
// Module  : rv64_pkg
// Brief   : Shared widths, constants and fetch FSM state type for the RV64 core
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv64_pkg;

    localparam int XLEN           = 64;
    localparam int INST_W         = 32;
    localparam int FETCH_BUS_W    = 96;
    localparam int FETCH_COMMIT_W = 161;

    localparam logic [INST_W-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_hold_buf.sv
//------------------------------------------------------------------------------
// Module  : fetch_hold_buf
// Brief   : One-entry instruction buffer used while decode is stalled
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_hold_buf
    import rv64_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [INST_W-1:0] din,
    output logic              valid,
    output logic [INST_W-1:0] instr
);

    logic              valid_q, valid_d;
    logic [INST_W-1:0] instr_q, instr_d;

    // Load wins over clear so a capture is never lost to a stale clear.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        if (load) begin
            valid_d = 1'b1;
            instr_d = din;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            instr_q <= RV_NOP;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module  : fetch_stage
// Brief   : RV64 instruction fetch: PC, single-outstanding imem read, redirect/stall
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
    import rv64_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [XLEN-1:0]           imem_req_addr,
    input  logic                      imem_resp_valid,
    input  logic [INST_W-1:0]         imem_resp_data,
    input  logic                      fetch_i_stall,
    input  logic                      fetch_i_redirect_valid,
    input  logic [XLEN-1:0]           fetch_i_redirect_pc,
    output logic [FETCH_BUS_W-1:0]    fetch_o_bus_info,
    output logic [FETCH_COMMIT_W-1:0] fetch_o_commit_info
);

    fetch_state_t      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              kill_q, kill_d;

    logic              hold_load, hold_clear, hold_valid;
    logic [INST_W-1:0] hold_instr;

    logic              out_valid;
    logic [INST_W-1:0] out_instr;
    logic [XLEN-1:0]   out_next_pc;
    logic [XLEN-1:0]   redirect_tgt;

    assign redirect_tgt = {fetch_i_redirect_pc[XLEN-1:2], 2'b00};

    fetch_hold_buf u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (hold_load),
        .clear (hold_clear),
        .din   (imem_resp_data),
        .valid (hold_valid),
        .instr (hold_instr)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        unique case (state_q)
            FETCH_IDLE: state_d = FETCH_REQ;
            FETCH_REQ: begin
                if (fetch_i_redirect_valid) begin
                    pc_d = redirect_tgt;
                    // An accepted request is already in flight to the old pc.
                    if (imem_req_ready) begin
                        state_d = FETCH_WAIT;
                        kill_d  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    state_d = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (fetch_i_redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (imem_resp_valid) begin
                        state_d = FETCH_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (kill_q) begin
                        state_d = FETCH_REQ;
                        kill_d  = 1'b0;
                    end else if (fetch_i_stall) begin
                        state_d   = FETCH_HOLD;
                        hold_load = 1'b1;
                    end else begin
                        state_d = FETCH_REQ;
                        pc_d    = pc_plus4(pc_q);
                    end
                end
            end
            FETCH_HOLD: begin
                if (fetch_i_redirect_valid) begin
                    pc_d       = redirect_tgt;
                    state_d    = FETCH_REQ;
                    hold_clear = 1'b1;
                end else if (!fetch_i_stall) begin
                    pc_d       = pc_plus4(pc_q);
                    state_d    = FETCH_REQ;
                    hold_clear = 1'b1;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_instr = RV_NOP;
        if (!fetch_i_redirect_valid) begin
            if (state_q == FETCH_WAIT && imem_resp_valid && !kill_q && !fetch_i_stall) begin
                out_valid = 1'b1;
                out_instr = imem_resp_data;
            end else if (state_q == FETCH_HOLD && hold_valid) begin
                out_valid = 1'b1;
                out_instr = hold_instr;
            end
        end
        out_next_pc = out_valid ? pc_plus4(pc_q) : pc_q;
    end

    assign imem_req_valid      = (state_q == FETCH_REQ);
    assign imem_req_addr       = pc_q;
    assign fetch_o_bus_info    = {out_instr, pc_q};
    assign fetch_o_commit_info = {out_valid, out_instr, out_next_pc, pc_q};

endmodule

`default_nettype wire
